mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between the core's instruction-fetch requester and its load/store requester.
- Sits between the core's imem/dmem interfaces and a unified instruction+data RAM.
- Allows one outstanding transaction at a time.
- Data side has priority, with a bounded-streak starvation guard for fetch.

Parameters:
XLEN, 32, address/data width
MEM_LATENCY, 1, cycles from mem_en (ISSUE cycle) to valid mem_rdata; legal range 1..15
MAX_DATA_STREAK, 4, max consecutive data grants while fetch is waiting; legal range >=1

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
if_req_valid  in  1  fetch request
if_req_ready  out  1  fetch request accepted
if_req_addr  in  XLEN  fetch byte address
if_rsp_valid  out  1  fetch data valid, one-cycle pulse
if_rsp_data  out  XLEN  fetched word
d_req_valid  in  1  data request
d_req_ready  out  1  data request accepted
d_req_addr  in  XLEN  data byte address
d_req_wen  in  1  1 = store, 0 = load
d_req_wdata  in  XLEN  store data
d_req_wstrb  in  XLEN/8  store byte enables
d_rsp_valid  out  1  load data / store done, one-cycle pulse
d_rsp_data  out  XLEN  load word; 0 for stores
mem_en  out  1  memory access strobe
mem_wen  out  1  memory write enable
mem_addr  out  XLEN  memory address; low bits passed unchanged
mem_wdata  out  XLEN  memory write data
mem_wstrb  out  XLEN/8  memory byte enables
mem_rdata  in  XLEN  memory read data

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, streak=0, latency counter=0, captured request regs=0.
  - All outputs 0.
  - An in-flight transaction is abandoned: no response, no memory strobe afterwards.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Ready outputs are combinational from the valids; at most one ready is high.
  - Data wins if d_req_valid && (!if_req_valid || streak < MAX_DATA_STREAK); otherwise fetch wins if if_req_valid.
  - On handshake (valid && ready): capture addr/wen/wdata/wstrb and requester id; go to ISSUE.
  - Fetch requests capture wen=0, wstrb=0.
- ISSUE (one cycle):
  - mem_en=1; mem_wen, mem_addr, mem_wdata, mem_wstrb driven from the captured regs.
  - Store: go to RESP.
  - Load/fetch: counter <= MEM_LATENCY-1; go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - When counter==0, mem_rdata is valid: register it; go to RESP.
  - Read data is therefore sampled in cycle ISSUE+MEM_LATENCY.
- RESP (one cycle):
  - Pulse the winner's rsp_valid with registered data (d_rsp_data=0 for a store).
  - Go to IDLE.
  - The rsp_data outputs hold their last value outside RESP.
- Ready outputs are 0 in every state except IDLE; requesters hold valid and payload until handshake.
- Memory outputs:
  - mem_en and mem_wen are 0 outside ISSUE.
  - mem_addr, mem_wdata, mem_wstrb are 0 outside ISSUE.
- Latency, handshake to rsp_valid:
  - Load/fetch: MEM_LATENCY+2 cycles.
  - Store: 2 cycles.
  - The next handshake can occur in the cycle after RESP.
- Streak counter:
  - On a data grant while if_req_valid=1: streak += 1, saturating at MAX_DATA_STREAK.
  - On a data grant with if_req_valid=0: no change.
  - On any fetch grant: streak = 0.
- Simultaneous events:
  - Both valid with streak < MAX: data granted.
  - Both valid with streak == MAX: fetch granted.
- Responses have no backpressure; requesters must always accept rsp pulses.
- A valid dropped before handshake is legal; nothing is captured.

Optional Feature:
- MEM_PORT_ARBITER_PERF_EN defined:
  - Adds outputs perf_if_grants, perf_d_grants, perf_stall_cycles (32 bits each).
  - Grant counters increment on each handshake for their side.
  - perf_stall_cycles increments every cycle in which any valid is high and its ready is low.
  - All three reset to 0 and wrap modulo 2^32.
- Undefined: these ports and their counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold reset=0 with random inputs -> all outputs 0. Release reset with if_req_valid=1 -> if_req_ready=1 in the first cycle.
- Fetch, MEM_LATENCY=2: handshake at cycle 0 on addr 0x100 -> mem_en=1, mem_addr=0x100 at cycle 1; mem_rdata=0xDEADBEEF at cycle 3 -> if_rsp_valid=1, if_rsp_data=0xDEADBEEF at cycle 4 only.
- Store: d_req addr 0x20, wdata 0x12345678, wstrb 0xF, wen=1 -> at ISSUE: mem_en=1, mem_wen=1, mem_wstrb=0xF for one cycle; d_rsp_valid=1, d_rsp_data=0 on the next cycle.
- Simultaneous: both valid at streak 0 -> data served first; fetch granted in the IDLE cycle after the data RESP.
- Starvation, MAX_DATA_STREAK=4: both valid continuously -> grant order D,D,D,D,F,D,D,D,D,F.
- Reset mid-WAIT: assert reset during WAIT -> no rsp_valid pulse, mem_en=0; after release, a new request is accepted immediately.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for one single-port synchronous RAM
// Optional perf counters are built when MEM_PORT_ARBITER_PERF_EN is defined.
module mem_port_arbiter #(
  parameter int XLEN            = 32,
  parameter int MEM_LATENCY     = 1,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [XLEN-1:0]   if_req_addr,
  output logic              if_rsp_valid,
  output logic [XLEN-1:0]   if_rsp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [XLEN-1:0]   d_req_addr,
  input  logic              d_req_wen,
  input  logic [XLEN-1:0]   d_req_wdata,
  input  logic [XLEN/8-1:0] d_req_wstrb,
  output logic              d_rsp_valid,
  output logic [XLEN-1:0]   d_rsp_data,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic [XLEN-1:0]   mem_rdata
`ifdef MEM_PORT_ARBITER_PERF_EN
  ,
  output logic [31:0]       perf_if_grants,
  output logic [31:0]       perf_d_grants,
  output logic [31:0]       perf_stall_cycles
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam int SB = XLEN / 8;

  logic [1:0]      state;
  logic [SW-1:0]   streak;
  logic [3:0]      lat_cnt;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [SB-1:0]   wstrb_q;
  logic            wen_q;
  logic            id_d_q;

  logic idle;
  logic issue;
  logic streak_full;
  logic d_grant;
  logic if_grant;

  // Readies are gated by reset so every output is 0 while reset is held.
  assign idle        = reset && (state == S_IDLE);
  assign issue       = (state == S_ISSUE);
  assign streak_full = (streak == SW'(MAX_DATA_STREAK));
  assign d_grant     = idle && d_req_valid && (!if_req_valid || !streak_full);
  assign if_grant    = idle && if_req_valid && !d_grant;

  assign d_req_ready  = d_grant;
  assign if_req_ready = if_grant;

  assign mem_en    = issue;
  assign mem_wen   = issue && wen_q;
  assign mem_addr  = issue ? addr_q  : '0;
  assign mem_wdata = issue ? wdata_q : '0;
  assign mem_wstrb = issue ? wstrb_q : '0;

  assign if_rsp_valid = (state == S_RESP) && !id_d_q;
  assign d_rsp_valid  = (state == S_RESP) && id_d_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      streak      <= '0;
      lat_cnt     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wen_q       <= 1'b0;
      id_d_q      <= 1'b0;
      if_rsp_data <= '0;
      d_rsp_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (d_grant) begin
            addr_q  <= d_req_addr;
            wen_q   <= d_req_wen;
            wdata_q <= d_req_wdata;
            wstrb_q <= d_req_wstrb;
            id_d_q  <= 1'b1;
            state   <= S_ISSUE;
            if (if_req_valid && !streak_full)
              streak <= streak + 1'b1;
          end else if (if_grant) begin
            addr_q  <= if_req_addr;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            id_d_q  <= 1'b0;
            streak  <= '0;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (wen_q) begin
            d_rsp_data <= '0;
            state      <= S_RESP;
          end else begin
            lat_cnt <= 4'(MEM_LATENCY - 1);
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (lat_cnt == 4'd0) begin
            if (id_d_q) d_rsp_data  <= mem_rdata;
            else        if_rsp_data <= mem_rdata;
            state <= S_RESP;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_PORT_ARBITER_PERF_EN
  logic stall;
  assign stall = (if_req_valid && !if_req_ready) || (d_req_valid && !d_req_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_if_grants    <= '0;
      perf_d_grants     <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (if_grant) perf_if_grants    <= perf_if_grants + 32'd1;
      if (d_grant)  perf_d_grants     <= perf_d_grants + 32'd1;
      if (stall)    perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a RAM model
module tb_mem_port_arbiter;
  localparam int XLEN = 32;
  localparam int L    = 2;
  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [31:0] if_req_addr, if_rsp_data;
  logic        d_req_valid, d_req_ready, d_req_wen, d_rsp_valid;
  logic [31:0] d_req_addr, d_req_wdata, d_rsp_data;
  logic [3:0]  d_req_wstrb;
  logic        mem_en, mem_wen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
`ifdef MEM_PORT_ARBITER_PERF_EN
  logic [31:0] perf_if_grants, perf_d_grants, perf_stall_cycles;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(XLEN), .MEM_LATENCY(L), .MAX_DATA_STREAK(MAXS)) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_wen(d_req_wen), .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
`ifdef MEM_PORT_ARBITER_PERF_EN
    , .perf_if_grants(perf_if_grants), .perf_d_grants(perf_d_grants),
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  function automatic logic [31:0] init_word(int i);
    if (i == 64) return 32'hDEADBEEF;
    return (32'(i) * 32'h9E3779B9) ^ 32'hA5A50000;
  endfunction

  int total = 0;
  int passed = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
    else passed++;
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {31'd0, act}, {31'd0, exp});
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // RAM environment: read data appears MEM_LATENCY cycles after the strobe, garbage otherwise
  logic [31:0] mem_ram [256];
  logic        pend = 1'b0;
  logic [3:0]  pend_cnt = 4'd0;
  logic [31:0] pend_data = 32'd0;
  logic [31:0] garbage = 32'd0;
  assign mem_rdata = (pend && pend_cnt == 4'd0) ? pend_data : garbage;

  always @(posedge clk) begin
    garbage <= $urandom;
    if (!reset) begin
      pend <= 1'b0;
      for (int i = 0; i < 256; i++) mem_ram[i] <= init_word(i);
    end else if (mem_en && mem_wen) begin
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) mem_ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end else if (mem_en) begin
      pend      <= 1'b1;
      pend_cnt  <= 4'(L - 1);
      pend_data <= mem_ram[mem_addr[9:2]];
    end else if (pend) begin
      if (pend_cnt == 4'd0) pend <= 1'b0;
      else pend_cnt <= pend_cnt - 4'd1;
    end
  end

  // Reference model and scoreboard
  typedef struct { bit is_d; logic [31:0] data; int cyc; int lat; } rsp_t;
  typedef struct { logic [31:0] addr; logic wen; logic [31:0] wdata; logic [3:0] wstrb; } mem_t;
  rsp_t        rsp_q [$];
  mem_t        mem_q [$];
  bit          grant_q [$];
  logic [31:0] ref_ram [256];
  int          streak_m = 0;
  bit          busy = 0;
  int          hs_cyc = 0;
  logic [31:0] last_if = 32'd0, last_d = 32'd0;

  always @(negedge clk) begin
    rsp_t r;
    mem_t m;
    bit   exp_d, exp_f;
    int   idx;
    if (!reset) begin
      check1("reset_outputs", |{if_req_ready, d_req_ready, if_rsp_valid, d_rsp_valid, if_rsp_data,
                                d_rsp_data, mem_en, mem_wen, mem_addr, mem_wdata, mem_wstrb}, 1'b0);
      rsp_q.delete(); mem_q.delete();
      busy = 0; streak_m = 0; last_if = 0; last_d = 0;
      for (int i = 0; i < 256; i++) ref_ram[i] = init_word(i);
    end else begin
      exp_d = !busy && d_req_valid && (!if_req_valid || streak_m < MAXS);
      exp_f = !busy && if_req_valid && !exp_d;
      check1("if_req_ready", if_req_ready, exp_f);
      check1("d_req_ready", d_req_ready, exp_d);
      if (d_req_valid && d_req_ready) begin
        idx = int'(d_req_addr[9:2]);
        r.is_d = 1; r.cyc = cyc;
        if (d_req_wen) begin
          r.data = 0; r.lat = 2;
          for (int b = 0; b < 4; b++)
            if (d_req_wstrb[b]) ref_ram[idx][8*b +: 8] = d_req_wdata[8*b +: 8];
        end else begin
          r.data = ref_ram[idx]; r.lat = L + 2;
        end
        m.addr = d_req_addr; m.wen = d_req_wen; m.wdata = d_req_wdata; m.wstrb = d_req_wstrb;
        if (if_req_valid && streak_m < MAXS) streak_m++;
        rsp_q.push_back(r); mem_q.push_back(m); grant_q.push_back(1'b1);
        busy = 1; hs_cyc = cyc;
      end else if (if_req_valid && if_req_ready) begin
        r.is_d = 0; r.cyc = cyc; r.lat = L + 2; r.data = ref_ram[int'(if_req_addr[9:2])];
        m.addr = if_req_addr; m.wen = 0; m.wdata = 0; m.wstrb = 0;
        streak_m = 0;
        rsp_q.push_back(r); mem_q.push_back(m); grant_q.push_back(1'b0);
        busy = 1; hs_cyc = cyc;
      end
      if (mem_en) begin
        if (mem_q.size() == 0) check1("mem_en_unexpected", 1'b1, 1'b0);
        else begin
          m = mem_q.pop_front();
          check("mem_addr", mem_addr, m.addr);
          check1("mem_wen", mem_wen, m.wen);
          check("mem_wdata", mem_wdata, m.wdata);
          check("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, m.wstrb});
        end
      end else begin
        check1("mem_idle_zero", |{mem_wen, mem_addr, mem_wdata, mem_wstrb}, 1'b0);
      end
      if (if_rsp_valid || d_rsp_valid) begin
        if (rsp_q.size() == 0) check1("rsp_unexpected", 1'b1, 1'b0);
        else begin
          r = rsp_q.pop_front();
          check1("rsp_both", if_rsp_valid && d_rsp_valid, 1'b0);
          check1("rsp_side", d_rsp_valid, r.is_d);
          check("rsp_data", d_rsp_valid ? d_rsp_data : if_rsp_data, r.data);
          check("rsp_latency", 32'(cyc - r.cyc), 32'(r.lat));
        end
        busy = 0;
      end else if (busy && (cyc - hs_cyc) > L + 4) begin
        check1("rsp_timeout", 1'b1, 1'b0);
        busy = 0; rsp_q.delete(); mem_q.delete();
      end
      if (!if_rsp_valid) check("if_rsp_data_hold", if_rsp_data, last_if);
      else last_if = if_rsp_data;
      if (!d_rsp_valid) check("d_rsp_data_hold", d_rsp_data, last_d);
      else last_d = d_rsp_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) step();
  endtask

  task automatic send_d(input logic [31:0] a, input logic w, input logic [31:0] wd, input logic [3:0] ws);
    bit got;
    got = 0;
    d_req_valid = 1; d_req_addr = a; d_req_wen = w; d_req_wdata = wd; d_req_wstrb = ws;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (d_req_ready) begin got = 1; break; end
    end
    if (!got) check1("send_d_timeout", 1'b0, 1'b1);
    step();
    d_req_valid = 0;
  endtask

  initial begin
    bit          fh, dh;
    logic [9:0]  exp_order;
    if_req_valid = 0; if_req_addr = 0;
    d_req_valid = 0; d_req_addr = 0; d_req_wen = 0; d_req_wdata = 0; d_req_wstrb = 0;

    repeat (5) begin
      step();
      if_req_valid = 1'($urandom); if_req_addr = $urandom;
      d_req_valid = 1'($urandom); d_req_addr = $urandom; d_req_wen = 1'($urandom);
      d_req_wdata = $urandom; d_req_wstrb = 4'($urandom);
    end

    // Release with a fetch pending: granted in the very first cycle
    if_req_valid = 1; if_req_addr = 32'h100; d_req_valid = 0; reset = 1;
    @(negedge clk);
    check1("release_if_ready", if_req_ready, 1'b1);
    step();
    if_req_valid = 0;
    idle_cycles(8);

    send_d(32'h20, 1'b1, 32'h12345678, 4'hF);
    idle_cycles(6);

    // Both sides always pending: bounded data streak then one fetch
    grant_q.delete();
    if_req_valid = 1; if_req_addr = $urandom & 32'h3FC;
    d_req_valid = 1; d_req_addr = $urandom & 32'h3FC; d_req_wen = 1'($urandom);
    d_req_wdata = $urandom; d_req_wstrb = 4'($urandom);
    for (int c = 0; c < 300 && grant_q.size() < 10; c++) begin
      @(negedge clk);
      fh = if_req_valid && if_req_ready;
      dh = d_req_valid && d_req_ready;
      step();
      if (fh) if_req_addr = $urandom & 32'h3FC;
      if (dh) begin
        d_req_addr = $urandom & 32'h3FC; d_req_wen = 1'($urandom);
        d_req_wdata = $urandom; d_req_wstrb = 4'($urandom);
      end
    end
    if_req_valid = 0; d_req_valid = 0;
    idle_cycles(8);
    exp_order = 10'b1111011110;
    check("grant_count", 32'(grant_q.size()), 32'd10);
    for (int i = 0; i < 10 && i < grant_q.size(); i++)
      check1($sformatf("grant_order_%0d", i), grant_q[i], exp_order[9-i]);

    // Reset during WAIT abandons the load
    send_d(32'h40, 1'b0, 32'h0, 4'h0);
    step();
    reset = 0;
    idle_cycles(2);
    d_req_valid = 1; d_req_addr = 32'h80; d_req_wen = 0; reset = 1;
    @(negedge clk);
    check1("post_reset_d_ready", d_req_ready, 1'b1);
    step();
    d_req_valid = 0;
    idle_cycles(8);

    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      fh = if_req_valid && if_req_ready;
      dh = d_req_valid && d_req_ready;
      step();
      if (fh || !if_req_valid) begin
        if_req_valid = ($urandom % 3) != 0; if_req_addr = $urandom & 32'h3FC;
      end else if ($urandom % 10 == 0) if_req_valid = 0;
      if (dh || !d_req_valid) begin
        d_req_valid = ($urandom % 3) != 0; d_req_addr = $urandom & 32'h3FC;
        d_req_wen = 1'($urandom); d_req_wdata = $urandom; d_req_wstrb = 4'($urandom);
      end else if ($urandom % 10 == 0) d_req_valid = 0;
    end
    if_req_valid = 0; d_req_valid = 0;
    idle_cycles(10);
    check("drain_rsp_q", 32'(rsp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
